mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage sitting between the ex_mem and mem_wb
//   registers. Non-memory instructions flow through combinationally. Loads
//   and stores issue a single request to the memory controller and hold the
//   pipeline (stall_req_o) until the controller reports completion. Load data
//   is sign/zero-extended before being handed to writeback.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ex_*_i            instruction from the ex_mem register (held while stalled)
//   flush_i           discard the current instruction
//   mc_*_o / mc_*_i   memory controller request / response
//   valid_o, wd_o, wreg_o, wdata_o   result toward mem_wb
//   stall_req_o       hold upstream stages this cycle
//   misaligned_o      one-cycle pulse for a misaligned load/store
//
// Controller handshake: mc_req_o stays high with stable request fields until
// a cycle where mc_ready_i=1 (the request is accepted on that edge). The
// response is a one-cycle mc_done_i pulse carrying mc_rdata_i, which may come
// in the accept cycle itself or any later cycle.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic [4:0]        ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [3:0]        ex_memop_i,
    input  logic [ADDR_W-1:0] ex_mem_addr_i,
    input  logic [DATA_W-1:0] ex_store_data_i,
    input  logic              flush_i,
    output logic              mc_req_o,
    output logic              mc_we_o,
    output logic [ADDR_W-1:0] mc_addr_o,
    output logic [1:0]        mc_size_o,
    output logic [DATA_W-1:0] mc_wdata_o,
    input  logic              mc_ready_i,
    input  logic              mc_done_i,
    input  logic [DATA_W-1:0] mc_rdata_i,
    output logic              valid_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stall_req_o,
    output logic              misaligned_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        memop_q, memop_d;   // memop of the access in flight
    logic [DATA_W-1:0] rdata_q, rdata_d;   // extended load result

    // memop encoding: 1=LB 2=LH 3=LW 4=LBU 5=LHU 6=SB 7=SH 8=SW
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: op_size = 2'd0;
            4'd2, 4'd5, 4'd7: op_size = 2'd1;
            default:          op_size = 2'd2;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [3:0] op,
                                                      input logic [DATA_W-1:0] d);
        case (op)
            4'd1:    load_extend = {{(DATA_W-8){d[7]}}, d[7:0]};
            4'd2:    load_extend = {{(DATA_W-16){d[15]}}, d[15:0]};
            4'd4:    load_extend = {{(DATA_W-8){1'b0}}, d[7:0]};
            4'd5:    load_extend = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: load_extend = d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_align(input logic [3:0] op,
                                                      input logic [DATA_W-1:0] d);
        case (op_size(op))
            2'd0:    store_align = {{(DATA_W-8){1'b0}}, d[7:0]};
            2'd1:    store_align = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: store_align = d;
        endcase
    endfunction

    logic       ex_is_mem;
    logic [1:0] ex_size;
    logic       ex_misaligned;

    assign ex_is_mem     = op_is_mem(ex_memop_i);
    assign ex_size       = op_size(ex_memop_i);
    assign ex_misaligned = ex_is_mem &&
                           (((ex_size == 2'd1) && ex_mem_addr_i[0]) ||
                            ((ex_size == 2'd2) && (ex_mem_addr_i[1:0] != 2'b00)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            memop_q <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            memop_q <= memop_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        memop_d      = memop_q;
        rdata_d      = rdata_q;
        mc_req_o     = 1'b0;
        mc_we_o      = 1'b0;
        mc_addr_o    = '0;
        mc_size_o    = 2'd0;
        mc_wdata_o   = '0;
        valid_o      = 1'b0;
        wd_o         = 5'd0;
        wreg_o       = 1'b0;
        wdata_o      = '0;
        stall_req_o  = 1'b0;
        misaligned_o = 1'b0;

        // Outputs are forced quiet while reset is held, so an abandoned
        // access cannot leak a stall or result during the reset pulse.
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (!ex_is_mem) begin
                        valid_o = ex_valid_i && !flush_i;
                        wd_o    = ex_wd_i;
                        wreg_o  = ex_wreg_i && ex_valid_i && !flush_i;
                        wdata_o = ex_wdata_i;
                    end else if (ex_valid_i && !flush_i) begin
                        if (ex_misaligned) begin
                            // Retire without writeback; no request issued.
                            misaligned_o = 1'b1;
                            valid_o      = 1'b1;
                            wd_o         = ex_wd_i;
                        end else begin
                            stall_req_o = 1'b1;
                            memop_d     = ex_memop_i;
                            state_d     = S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    mc_req_o    = 1'b1;
                    mc_we_o     = !op_is_load(memop_q);
                    mc_addr_o   = ex_mem_addr_i;
                    mc_size_o   = op_size(memop_q);
                    mc_wdata_o  = store_align(memop_q, ex_store_data_i);
                    stall_req_o = 1'b1;
                    if (mc_ready_i) begin
                        if (mc_done_i) begin
                            rdata_d = load_extend(memop_q, mc_rdata_i);
                            // Access already finished: a flush just drops it.
                            state_d = flush_i ? S_IDLE : S_DONE;
                        end else begin
                            state_d = flush_i ? S_DRAIN : S_WAIT;
                        end
                    end else if (flush_i) begin
                        state_d = S_IDLE;
                    end
                end

                S_WAIT: begin
                    stall_req_o = 1'b1;
                    if (mc_done_i) begin
                        rdata_d = load_extend(memop_q, mc_rdata_i);
                        state_d = flush_i ? S_IDLE : S_DONE;
                    end else if (flush_i) begin
                        state_d = S_DRAIN;
                    end
                end

                S_DONE: begin
                    valid_o = 1'b1;
                    wd_o    = ex_wd_i;
                    if (op_is_load(memop_q)) begin
                        wreg_o  = ex_wreg_i;
                        wdata_o = rdata_q;
                    end
                    state_d = S_IDLE;
                end

                S_DRAIN: begin
                    // Accepted access must complete before the stage is reused.
                    stall_req_o = 1'b1;
                    if (mc_done_i) begin
                        state_d = S_IDLE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage. The bench plays both the upstream
//   pipeline and the memory controller; expected values come from a
//   transaction-level model of the memop rules (size, extension, alignment)
//   and the cycle timeline of an access.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic        flush;
    logic        mc_req, mc_we;
    logic [31:0] mc_addr;
    logic [1:0]  mc_size;
    logic [31:0] mc_wdata;
    logic        mc_ready, mc_done;
    logic [31:0] mc_rdata;
    logic        valid, wreg, stall, misaligned;
    logic [4:0]  wd;
    logic [31:0] wdata;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg),
        .ex_wdata_i(ex_wdata), .ex_memop_i(ex_memop), .ex_mem_addr_i(ex_addr),
        .ex_store_data_i(ex_sdata), .flush_i(flush),
        .mc_req_o(mc_req), .mc_we_o(mc_we), .mc_addr_o(mc_addr),
        .mc_size_o(mc_size), .mc_wdata_o(mc_wdata),
        .mc_ready_i(mc_ready), .mc_done_i(mc_done), .mc_rdata_i(mc_rdata),
        .valid_o(valid), .wd_o(wd), .wreg_o(wreg), .wdata_o(wdata),
        .stall_req_o(stall), .misaligned_o(misaligned)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_size(input logic [3:0] op);
        if (op == 1 || op == 4 || op == 6) return 2'd0;
        if (op == 2 || op == 5 || op == 7) return 2'd1;
        return 2'd2;
    endfunction

    function automatic bit m_is_load(input logic [3:0] op);
        return op >= 1 && op <= 5;
    endfunction

    function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] rd);
        int unsigned v;
        case (op)
            1: begin v = rd % 256;   return (v >= 128)   ? v - 256   : v; end
            2: begin v = rd % 65536; return (v >= 32768) ? v - 65536 : v; end
            4: return rd % 256;
            5: return rd % 65536;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] m_store_val(input logic [3:0] op, input logic [31:0] sd);
        case (m_size(op))
            2'd0:    return sd % 256;
            2'd1:    return sd % 65536;
            default: return sd;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ex_valid = 1'b0; ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'd0;
        ex_memop = 4'd0; ex_addr = 32'd0; ex_sdata = 32'd0; flush = 1'b0;
        mc_ready = 1'b0; mc_done = 1'b0; mc_rdata = 32'd0;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [4:0] d, input logic w);
        ex_valid = 1'b1; ex_memop = op; ex_addr = addr; ex_sdata = sd;
        ex_wd = d; ex_wreg = w; ex_wdata = $urandom;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [4:0] d, input logic w,
                          input logic [31:0] data, input logic v, input logic fl);
        ex_valid = v; ex_memop = op; ex_wd = d; ex_wreg = w; ex_wdata = data;
        flush = fl; mc_ready = 1'b0; mc_done = 1'b0;
        #4;
        check("alu_valid", valid, v && !fl);
        if (v && !fl) begin
            check("alu_wd", wd, d);
            check("alu_wreg", wreg, w);
            check("alu_wdata", wdata, data);
        end
        check("alu_stall", stall, 0);
        check("alu_req", mc_req, 0);
        tick();
        set_idle();
    endtask

    // Aligned access: ready after r REQ cycles, done d cycles after acceptance.
    task automatic mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rd, input logic [4:0] d, input logic w,
                          input int r, input int dl);
        int req_cnt = 0;
        int stall_cnt = 0;
        present(op, addr, sd, d, w);
        mc_rdata = rd;
        #4;
        check("launch_stall", stall, 1);
        check("launch_valid", valid, 0);
        check("launch_req", mc_req, 0);
        check("launch_mis", misaligned, 0);
        stall_cnt += int'(stall);
        tick();
        for (int i = 0; i <= r; i++) begin
            mc_ready = (i == r);
            mc_done  = (i == r) && (dl == 0);
            #4;
            check("req_we", mc_we, !m_is_load(op));
            check("req_addr", mc_addr, addr);
            check("req_size", mc_size, m_size(op));
            check("req_wdata", mc_wdata, m_store_val(op, sd));
            check("req_valid", valid, 0);
            req_cnt += int'(mc_req);
            stall_cnt += int'(stall);
            tick();
        end
        mc_ready = 1'b0;
        mc_done = 1'b0;
        for (int i = 1; i <= dl; i++) begin
            mc_done = (i == dl);
            #4;
            check("wait_req", mc_req, 0);
            check("wait_valid", valid, 0);
            req_cnt += int'(mc_req);
            stall_cnt += int'(stall);
            tick();
        end
        mc_done = 1'b0;
        mc_rdata = $urandom;
        #4;
        check("done_valid", valid, 1);
        check("done_stall", stall, 0);
        check("done_wd", wd, d);
        check("done_wreg", wreg, m_is_load(op) ? w : 1'b0);
        check("done_wdata", wdata, m_is_load(op) ? m_load_val(op, rd) : 32'd0);
        check("req_cycles", req_cnt, r + 1);
        check("stall_cycles", stall_cnt, 1 + (r + 1) + dl);
        tick();
        set_idle();
    endtask

    task automatic mis_op(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] d);
        present(op, addr, $urandom, d, 1'b1);
        #4;
        check("mis_pulse", misaligned, 1);
        check("mis_valid", valid, 1);
        check("mis_wreg", wreg, 0);
        check("mis_req", mc_req, 0);
        check("mis_stall", stall, 0);
        tick();
        set_idle();
        #4;
        check("mis_after_pulse", misaligned, 0);
        check("mis_after_req", mc_req, 0);
        check("mis_after_stall", stall, 0);
        tick();
    endtask

    task automatic flush_req(input logic [3:0] op, input logic [31:0] addr, input int r);
        present(op, addr, $urandom, 5'd3, 1'b1);
        #4;
        check("freq_launch_stall", stall, 1);
        tick();
        for (int i = 0; i < r; i++) begin
            #4;
            check("freq_req", mc_req, 1);
            tick();
        end
        flush = 1'b1;
        #4;
        check("freq_flush_req", mc_req, 1);
        check("freq_flush_valid", valid, 0);
        tick();
        set_idle();
        #4;
        check("freq_after_req", mc_req, 0);
        check("freq_after_stall", stall, 0);
        check("freq_after_valid", valid, 0);
        tick();
    endtask

    task automatic flush_wait(input logic [3:0] op, input logic [31:0] addr,
                              input int r, input int d1, input int d2);
        present(op, addr, $urandom, 5'd7, 1'b1);
        mc_rdata = $urandom;
        tick();
        for (int i = 0; i <= r; i++) begin
            mc_ready = (i == r);
            tick();
        end
        mc_ready = 1'b0;
        for (int i = 0; i < d1; i++) tick();
        flush = 1'b1;
        #4;
        check("fwait_stall", stall, 1);
        check("fwait_req", mc_req, 0);
        tick();
        set_idle();
        for (int i = 1; i <= d2; i++) begin
            mc_done = (i == d2);
            #4;
            check("drain_stall", stall, 1);
            check("drain_valid", valid, 0);
            check("drain_req", mc_req, 0);
            tick();
        end
        mc_done = 1'b0;
        #4;
        check("drain_exit_stall", stall, 0);
        check("drain_exit_valid", valid, 0);
        check("drain_exit_wreg", wreg, 0);
        tick();
    endtask

    task automatic reset_in_wait();
        present(4'd3, 32'h300, 32'd0, 5'd9, 1'b1);
        tick();
        mc_ready = 1'b1;
        tick();
        mc_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_req", mc_req, 0);
        check("rst_valid", valid, 0);
        check("rst_wreg", wreg, 0);
        check("rst_wd", wd, 0);
        check("rst_wdata", wdata, 0);
        check("rst_mis", misaligned, 0);
        tick();
        rst = 1'b0;
        set_idle();
        mc_done = 1'b1;
        mc_rdata = 32'h1234_5678;
        #4;
        check("stray_done_valid", valid, 0);
        check("stray_done_stall", stall, 0);
        tick();
        mc_done = 1'b0;
        #4;
        check("post_stray_valid", valid, 0);
        check("post_stray_stall", stall, 0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] mis_ops [5];
        mis_ops[0] = 4'd2; mis_ops[1] = 4'd5; mis_ops[2] = 4'd7;
        mis_ops[3] = 4'd3; mis_ops[4] = 4'd8;

        set_idle();
        rst = 1'b1;
        ex_valid = 1'b1; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h55;
        #3;
        check("reset_valid", valid, 0);
        check("reset_wd", wd, 0);
        check("reset_wdata", wdata, 0);
        check("reset_stall", stall, 0);
        check("reset_req", mc_req, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();

        // Directed cases
        alu_op(4'd0, 5'd5, 1'b1, 32'h1234, 1'b1, 1'b0);
        mem_op(4'd1, 32'h100, 32'd0, 32'h80, 5'd4, 1'b1, 2, 2);
        mem_op(4'd4, 32'h100, 32'd0, 32'h80, 5'd4, 1'b1, 2, 2);
        mem_op(4'd8, 32'h200, 32'hDEADBEEF, 32'd0, 5'd6, 1'b1, 0, 0);
        mis_op(4'd3, 32'h102, 5'd8);
        flush_wait(4'd2, 32'h104, 1, 1, 2);
        flush_req(4'd3, 32'h108, 1);
        alu_op(4'd0, 5'd2, 1'b1, 32'hCAFE, 1'b1, 1'b1);
        reset_in_wait();

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 5);
            logic [3:0] op;
            logic [31:0] addr;
            case (kind)
                0: begin
                    op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                    alu_op(op, 5'($urandom), 1'($urandom), $urandom,
                           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
                end
                1, 2: begin
                    op = 4'($urandom_range(1, 8));
                    addr = $urandom;
                    if (m_size(op) == 2'd1) addr = addr - addr % 2;
                    if (m_size(op) == 2'd2) addr = addr - addr % 4;
                    mem_op(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                           $urandom_range(0, 3), $urandom_range(0, 3));
                end
                3: begin
                    op = mis_ops[$urandom_range(0, 4)];
                    addr = $urandom;
                    if (m_size(op) == 2'd1) addr = addr - addr % 2 + 1;
                    else addr = addr - addr % 4 + $urandom_range(1, 3);
                    mis_op(op, addr, 5'($urandom));
                end
                4: flush_req(4'($urandom_range(1, 8)), 32'h400, $urandom_range(0, 2));
                default: flush_wait(4'($urandom_range(1, 5)), 32'h800,
                                    $urandom_range(0, 2), $urandom_range(0, 2),
                                    $urandom_range(1, 3));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
